ball_motion_ctrl: RTL

//   Next-generation Pong ball engine. Moves the ball one step per frame tick, with a programmable step.

---
 rtl/pong_pkg.sv | 23 ++
 rtl/paddle_overlap.sv | 19 +
 rtl/ball_motion_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared Pong types and screen/paddle geometry for the ball engine.
package pong_pkg;

   typedef enum logic [1:0] {StIdle, StServeWait, StPlay, StScored} state_e;

   localparam int unsigned X_W         = 8;
   localparam int unsigned Y_W         = 9;
   localparam int unsigned SIZE        = 10;
   localparam int unsigned MIN_X       = 0;
   localparam int unsigned MAX_X       = 239;
   localparam int unsigned MIN_Y       = 30;
   localparam int unsigned MAX_Y       = 290;
   localparam int unsigned START_X     = 115;
   localparam int unsigned START_Y     = 155;
   localparam int unsigned PADDLE_W    = 5;
   localparam int unsigned PADDLE_H    = 41;
   localparam int unsigned SPEED_MAX   = 4;
   localparam int unsigned SERVE_DELAY = 60;

   localparam int unsigned SPEED_W = $clog2(SPEED_MAX + 1);
   localparam int unsigned CNT_W   = $clog2(SERVE_DELAY);

endpackage

// File: rtl/paddle_overlap.sv
// Vertical overlap test between the ball and one paddle (combinational).
module paddle_overlap
   import pong_pkg::*;
(
   input  logic [X_W-1:0] ball_x_i,
   input  logic [X_W-1:0] paddle_x_i,
   output logic           overlap_o
);

   logic [X_W:0] ball_bot, paddle_bot;

   // One extra bit so the bottom edges never wrap.
   always_comb begin
      ball_bot   = {1'b0, ball_x_i} + (X_W+1)'(SIZE);
      paddle_bot = {1'b0, paddle_x_i} + (X_W+1)'(PADDLE_H);
      overlap_o  = (ball_bot > {1'b0, paddle_x_i}) && ({1'b0, ball_x_i} < paddle_bot);
   end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Pong ball engine: serve/pause FSM, wall and paddle bounces, speed-up and goal detection.
module ball_motion_ctrl
   import pong_pkg::*;
(
   input  logic           clock,
   input  logic           reset,
   input  logic           tick,
   input  logic           serve,
   input  logic           pause,
   input  logic [X_W-1:0] player_1_x,
   input  logic [X_W-1:0] player_2_x,
   output logic [X_W-1:0] ball_x,
   output logic [Y_W-1:0] ball_y,
   output logic           player_1_scored,
   output logic           player_2_scored,
   output logic           paddle_hit,
   output logic           in_play
);

   localparam logic [X_W:0]       XMinE     = (X_W+1)'(MIN_X);
   localparam logic [X_W:0]       XMaxE     = (X_W+1)'(MAX_X);
   localparam logic [X_W:0]       XSizeE    = (X_W+1)'(SIZE);
   localparam logic [Y_W:0]       YMinE     = (Y_W+1)'(MIN_Y);
   localparam logic [Y_W:0]       YFace1E   = (Y_W+1)'(MIN_Y + PADDLE_W);
   localparam logic [Y_W:0]       YFace2E   = (Y_W+1)'(MAX_Y - SIZE);
   localparam logic [CNT_W-1:0]   CntLast   = CNT_W'(SERVE_DELAY - 1);
   localparam logic [SPEED_W-1:0] SpeedMaxC = SPEED_W'(SPEED_MAX);
   localparam logic [SPEED_W-1:0] SpeedOne  = SPEED_W'(1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [X_W-1:0]     x_q, x_d;
   logic [Y_W-1:0]     y_q, y_d;
   logic [SPEED_W-1:0] speed_q, speed_d;
   logic               dir_x_q, dir_x_d;  // 1: increasing x
   logic               dir_y_q, dir_y_d;  // 1: increasing y (toward paddle 2)
   logic               p1_scored_q, p1_scored_d;
   logic               p2_scored_q, p2_scored_d;
   logic               hit_q, hit_d;
   logic               in_play_q, in_play_d;

   logic               ov1, ov2, move;
   logic [X_W:0]       x_ext, spd_x, nx;
   logic [Y_W:0]       y_ext, spd_y, ny;
   logic [SPEED_W-1:0] speed_bump;

   paddle_overlap u_overlap_1 (
      .ball_x_i   (x_q),
      .paddle_x_i (player_1_x),
      .overlap_o  (ov1)
   );

   paddle_overlap u_overlap_2 (
      .ball_x_i   (x_q),
      .paddle_x_i (player_2_x),
      .overlap_o  (ov2)
   );

   // Next-state: FSM, serve countdown and one motion step per unpaused tick.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      x_d         = x_q;
      y_d         = y_q;
      speed_d     = speed_q;
      dir_x_d     = dir_x_q;
      dir_y_d     = dir_y_q;
      p1_scored_d = 1'b0;
      p2_scored_d = 1'b0;
      hit_d       = 1'b0;
      move        = tick && !pause;

      x_ext      = {1'b0, x_q};
      y_ext      = {1'b0, y_q};
      spd_x      = (X_W+1)'(speed_q);
      spd_y      = (Y_W+1)'(speed_q);
      speed_bump = (speed_q < SpeedMaxC) ? speed_q + SpeedOne : speed_q;
      // Decrements saturate at zero so the wall/goal compares never see a wrapped value.
      nx = dir_x_q ? x_ext + spd_x : ((x_ext > spd_x) ? x_ext - spd_x : '0);
      ny = dir_y_q ? y_ext + spd_y : ((y_ext > spd_y) ? y_ext - spd_y : '0);

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (serve) state_d = StServeWait;
         end
         StServeWait: begin
            if (move) begin
               if (cnt_q == CntLast) begin
                  state_d = StPlay;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StPlay: begin
            if (move) begin
               if (nx <= XMinE) begin
                  x_d     = X_W'(MIN_X);
                  dir_x_d = 1'b1;
               end else if (nx + XSizeE >= XMaxE) begin
                  x_d     = X_W'(MAX_X - SIZE);
                  dir_x_d = 1'b0;
               end else begin
                  x_d = nx[X_W-1:0];
               end

               if (!dir_y_q && ny <= YFace1E) begin
                  if (ov1) begin
                     y_d     = Y_W'(MIN_Y + PADDLE_W);
                     dir_y_d = 1'b1;
                     speed_d = speed_bump;
                     hit_d   = 1'b1;
                  end else if (ny <= YMinE) begin
                     p2_scored_d = 1'b1;
                  end else begin
                     // Missed the paddle but not yet in the goal: keep travelling.
                     y_d = ny[Y_W-1:0];
                  end
               end else if (dir_y_q && ny >= YFace2E) begin
                  if (ov2) begin
                     y_d     = Y_W'(MAX_Y - SIZE);
                     dir_y_d = 1'b0;
                     speed_d = speed_bump;
                     hit_d   = 1'b1;
                  end else begin
                     p1_scored_d = 1'b1;
                  end
               end else begin
                  y_d = ny[Y_W-1:0];
               end

               if (p1_scored_d || p2_scored_d) begin
                  state_d = StScored;
                  x_d     = X_W'(START_X);
                  y_d     = Y_W'(START_Y);
                  speed_d = SpeedOne;
                  // Next serve heads toward the player who conceded.
                  dir_y_d = p1_scored_d;
               end
            end
         end
         StScored: begin
            state_d = StServeWait;
            cnt_d   = '0;
         end
      endcase

      in_play_d = (state_d == StPlay);
   end

   // State and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         x_q         <= X_W'(START_X);
         y_q         <= Y_W'(START_Y);
         speed_q     <= SpeedOne;
         dir_x_q     <= 1'b1;
         dir_y_q     <= 1'b1;
         p1_scored_q <= 1'b0;
         p2_scored_q <= 1'b0;
         hit_q       <= 1'b0;
         in_play_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         speed_q     <= speed_d;
         dir_x_q     <= dir_x_d;
         dir_y_q     <= dir_y_d;
         p1_scored_q <= p1_scored_d;
         p2_scored_q <= p2_scored_d;
         hit_q       <= hit_d;
         in_play_q   <= in_play_d;
      end
   end

   assign ball_x          = x_q;
   assign ball_y          = y_q;
   assign player_1_scored = p1_scored_q;
   assign player_2_scored = p2_scored_q;
   assign paddle_hit      = hit_q;
   assign in_play         = in_play_q;

endmodule
